branch_predictor_nw: RTL
========================

Name: branch_predictor_nw

Overview:
Next-generation fetch-stage branch predictor for a FETCH_W-wide fetch packet. It combines a tagged direct-mapped BTB with 2-bit saturating counters and a return address stack (RAS) with mispredict checkpoint recovery. It sits between the PC generator and the IF stage and is trained by the EX stage. Unlike the current dual-issue unit, lane count, table depth and RAS depth are parametrised, and calls/returns are predicted.

Parameters:
ADDR_W, 32, address width; bits [1:0] are ignored.
FETCH_W, 2, lanes per fetch packet; power of two, 1..4; LANE_W = max(1, log2(FETCH_W)).
IDX_W, 6, BTB index bits; 2^IDX_W entries.
TAG_W, 10, BTB tag bits.
RAS_DEPTH, 8, RAS entries; power of two; PTR_W = log2(RAS_DEPTH).

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
if_vld  in  1  fetch packet presented this cycle; each packet is presented exactly once
if_pc  in  ADDR_W  PC of first instruction to fetch; may be mid-packet
ex_vld  in  1  EX update valid
ex_pc  in  ADDR_W  PC of the resolved branch
ex_tar  in  ADDR_W  resolved target
ex_type  in  2  00 cond, 01 direct jump, 10 call, 11 return
ex_taken  in  1  branch actually taken (ignored for types 01/10/11, which are treated as taken)
ex_wrong  in  1  prediction was wrong; triggers recovery
ex_ras_ptr  in  PTR_W  pd_ras_ptr carried with the instruction
pd_vld  out  1  prediction valid
pd_pc  out  ADDR_W  next fetch PC
pd_taken  out  1  a taken branch was predicted
pd_lane  out  LANE_W  lane of the predicting branch; 0 if not taken
pd_ras_ptr  out  PTR_W  RAS top pointer before this packet's RAS operation

Behaviour:
- Reset: all outputs 0; all BTB valid bits 0; counters 2'b01; RAS pointer 0; RAS data 0. Reset mid-operation drops any in-flight prediction.
- Latency 1: if_vld at cycle t gives pd_* registered at t+1. If if_vld=0 at t, pd_vld=0 at t+1.
- Packet: base = if_pc with bits [log2(FETCH_W)+1:0] cleared; lane k PC = base + 4k; start lane s = if_pc[log2(FETCH_W)+1:2]. Lanes below s are ignored.
- BTB lookup per lane: idx = pc[IDX_W+1:2], tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Hit = valid and tag match.
- A hit lane is taken if its type != 00, or if its counter >= 2'b10.
- Winner: the lowest lane k >= s that is taken.
  - Winner exists: pd_taken=1, pd_lane=k, pd_pc = RAS top if type 11, else the stored target.
  - No winner: pd_taken=0, pd_pc = base + 4*FETCH_W, with wrap-around modulo 2^ADDR_W.
- RAS speculative ops, only when if_vld=1 and ex_wrong=0 (winner type decides):
  - Call: write (winner PC + 4) at ptr+1, then ptr <= ptr+1.
  - Return: ptr <= ptr-1.
  - Pointer wraps modulo RAS_DEPTH. Overflow overwrites the oldest entry. Underflow returns the stale entry; no error.
- Recovery, on ex_vld=1 and ex_wrong=1, with priority over any if-side RAS op:
  - Call: write ex_pc+4 at ex_ras_ptr+1, ptr <= ex_ras_ptr+1.
  - Return: ptr <= ex_ras_ptr-1.
  - Otherwise: ptr <= ex_ras_ptr.
  - pd_vld at the next cycle is forced to 0.
- BTB training, on ex_vld=1 (whether or not ex_wrong):
  - Hit at ex_pc: update target and type; for cond, counter saturates up if taken, down if not; for other types, counter is set to 2'b11.
  - Miss, branch taken: allocate (overwrite) with valid=1, tag, target, type; counter 2'b10 for cond, 2'b11 otherwise.
  - Miss, not taken: no allocation.
- Read/write same index in the same cycle: lookup sees the old contents; the write is visible from the next cycle. No bypass.
- If two lanes of one packet alias the same index, each lane compares its own tag independently.

Decomposition:
- Package bp_pkg holds:
  - branch type encoding (BR_COND, BR_JUMP, BR_CALL, BR_RET);
  - counter constants (CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11);
  - saturating-counter update function.
- One sub-module, bp_ras: circular stack with push, pop and checkpoint-restore ports, synchronous active-low reset.

Test Plan:
- Reset, then if_vld with if_pc=0x1000, FETCH_W=2 -> pd_vld=1 one cycle later, pd_taken=0, pd_pc=0x1008.
- EX cond at 0x1004, taken, target 0x2000 (miss, allocated at counter 10); then if_pc=0x1000 -> pd_taken=1, pd_lane=1, pd_pc=0x2000. Then two not-taken updates -> pd_pc=0x1008.
- Same trained BTB, if_pc=0x1004 (start lane 1) -> lane 1 predicts 0x2000. Jump trained at 0x1000 with if_pc=0x1004 -> lane 0 is ignored.
- Call trained at 0x3000 (target 0x4000), return trained at 0x4010: fetch 0x3000 -> pd_pc=0x4000, pd_ras_ptr=0; fetch 0x4010 -> pd_pc=0x3004, pd_ras_ptr=1.
- Nine calls with RAS_DEPTH=8 -> pointer wraps to 1 and the first entry is overwritten. Then ex_wrong with ex_type=00 and ex_ras_ptr=3 -> next pd_vld=0 and pointer=3.
- ex_vld update and if lookup on the same index in the same cycle -> the lookup uses the old entry; the update is seen one cycle later. Also if_pc=0xFFFFFFF8 with no hit -> pd_pc=0x00000000.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: branch kind encoding, 2-bit counter states, counter update.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package bp_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JUMP = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Saturating 2-bit counter step toward the resolved direction
  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return address stack with push, pop and checkpoint-restore of the top pointer.
// Latency: top_dat/ptr reflect the current state; updates land at the next clock edge.
// Backpressure: none; overflow overwrites the oldest entry, underflow reads a stale entry.
module bp_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              restore_vld,
  input  logic [PTR_W-1:0]  restore_ptr,
  input  logic              push_vld,
  input  logic [ADDR_W-1:0] push_dat,
  input  logic              pop_vld,
  output logic [ADDR_W-1:0] top_dat,
  output logic [PTR_W-1:0]  ptr
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  base_ptr, wr_ptr;

  // Restore picks the checkpoint as the base, then push/pop are applied relative to it
  always_comb begin
    mem_d    = mem_q;
    base_ptr = restore_vld ? restore_ptr : ptr_q;
    wr_ptr   = base_ptr + PTR_W'(1);
    ptr_d    = base_ptr;
    if (push_vld) begin
      mem_d[wr_ptr] = push_dat;
      ptr_d         = wr_ptr;
    end else if (pop_vld) begin
      ptr_d = base_ptr - PTR_W'(1);
    end
  end

  // Stack state registers with synchronous clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      mem_q <= mem_d;
    end
  end

  assign top_dat = mem_q[ptr_q];
  assign ptr     = ptr_q;

endmodule

// File: rtl/branch_predictor_nw.sv
// Fetch-packet branch predictor: tagged direct-mapped BTB with 2-bit counters plus a RAS.
// Latency: one cycle from if_vld to registered pd_*; BTB training visible the cycle after ex_vld.
// Backpressure: none; every packet gets a prediction, recovery squashes the next pd_vld.
module branch_predictor_nw
  import bp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int FETCH_W   = 2,
  parameter int IDX_W     = 6,
  parameter int TAG_W     = 10,
  parameter int RAS_DEPTH = 8,
  localparam int LANE_W   = (FETCH_W > 1) ? $clog2(FETCH_W) : 1,
  localparam int PTR_W    = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_vld,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              ex_vld,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_tar,
  input  logic [1:0]        ex_type,
  input  logic              ex_taken,
  input  logic              ex_wrong,
  input  logic [PTR_W-1:0]  ex_ras_ptr,
  output logic              pd_vld,
  output logic [ADDR_W-1:0] pd_pc,
  output logic              pd_taken,
  output logic [LANE_W-1:0] pd_lane,
  output logic [PTR_W-1:0]  pd_ras_ptr
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [ADDR_W-1:0] PKT_BYTES = ADDR_W'(FETCH_W * 4);

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] tar;
    br_type_e          typ;
    logic [1:0]        cnt;
  } btb_ent_t;

  btb_ent_t btb_q [ENTRIES];
  btb_ent_t btb_d [ENTRIES];

  // Lookup side
  logic [ADDR_W-1:0] pkt_base;
  logic [LANE_W-1:0] start_lane;
  logic [ADDR_W-1:0] lane_pc  [FETCH_W];
  btb_ent_t          lane_ent [FETCH_W];
  logic [FETCH_W-1:0] lane_hit, lane_tkn;
  logic              win_found;
  logic [LANE_W-1:0] win_lane;
  logic [ADDR_W-1:0] win_pc;
  btb_ent_t          win_ent;

  // Training side
  logic [IDX_W-1:0]  ex_idx;
  logic [TAG_W-1:0]  ex_tag;
  btb_ent_t          ex_ent;
  br_type_e          ex_typ;
  logic              ex_hit, ex_tkn;

  // RAS hookup
  logic              recover;
  logic              if_ras_op;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_push_dat;
  logic [ADDR_W-1:0] ras_top;
  logic [PTR_W-1:0]  ras_ptr;

  // Prediction registers
  logic              pd_vld_q, pd_vld_d;
  logic [ADDR_W-1:0] pd_pc_q, pd_pc_d;
  logic              pd_taken_q, pd_taken_d;
  logic [LANE_W-1:0] pd_lane_q, pd_lane_d;
  logic [PTR_W-1:0]  pd_ras_ptr_q, pd_ras_ptr_d;

  // Per-lane BTB lookup and lowest-taken-lane selection from the start lane upward
  always_comb begin
    pkt_base   = if_pc & ~(PKT_BYTES - ADDR_W'(1));
    start_lane = LANE_W'((if_pc - pkt_base) >> 2);
    lane_hit   = '0;
    lane_tkn   = '0;
    win_found  = 1'b0;
    win_lane   = '0;
    win_pc     = '0;
    win_ent    = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      lane_pc[k]  = pkt_base + ADDR_W'(4 * k);
      lane_ent[k] = btb_q[IDX_W'(lane_pc[k] >> 2)];
      lane_hit[k] = lane_ent[k].vld &&
                    (lane_ent[k].tag == TAG_W'(lane_pc[k] >> (IDX_W + 2)));
      lane_tkn[k] = lane_hit[k] &&
                    ((lane_ent[k].typ != BR_COND) || (lane_ent[k].cnt >= CNT_WT));
      if (!win_found && lane_tkn[k] && (k >= int'(start_lane))) begin
        win_found = 1'b1;
        win_lane  = LANE_W'(k);
        win_pc    = lane_pc[k];
        win_ent   = lane_ent[k];
      end
    end
  end

  // RAS control: EX recovery restores the checkpoint and replays its own call/return,
  // otherwise the fetch-side winner speculatively pushes or pops
  always_comb begin
    recover   = ex_vld && ex_wrong;
    if_ras_op = if_vld && !ex_wrong && win_found;
    if (recover) begin
      ras_push     = (ex_type == BR_CALL);
      ras_pop      = (ex_type == BR_RET);
      ras_push_dat = ex_pc + ADDR_W'(4);
    end else begin
      ras_push     = if_ras_op && (win_ent.typ == BR_CALL);
      ras_pop      = if_ras_op && (win_ent.typ == BR_RET);
      ras_push_dat = win_pc + ADDR_W'(4);
    end
  end

  bp_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rstn        (rstn),
    .restore_vld (recover),
    .restore_ptr (ex_ras_ptr),
    .push_vld    (ras_push),
    .push_dat    (ras_push_dat),
    .pop_vld     (ras_pop),
    .top_dat     (ras_top),
    .ptr         (ras_ptr)
  );

  // Next prediction; a recovery in the same cycle squashes it
  always_comb begin
    pd_vld_d     = if_vld && !recover;
    pd_taken_d   = 1'b0;
    pd_lane_d    = '0;
    pd_pc_d      = '0;
    pd_ras_ptr_d = '0;
    if (pd_vld_d) begin
      pd_ras_ptr_d = ras_ptr;
      if (win_found) begin
        pd_taken_d = 1'b1;
        pd_lane_d  = win_lane;
        pd_pc_d    = (win_ent.typ == BR_RET) ? ras_top : win_ent.tar;
      end else begin
        pd_pc_d = pkt_base + PKT_BYTES;
      end
    end
  end

  // BTB training: refresh on hit, allocate only for taken misses
  always_comb begin
    btb_d  = btb_q;
    ex_idx = IDX_W'(ex_pc >> 2);
    ex_tag = TAG_W'(ex_pc >> (IDX_W + 2));
    ex_ent = btb_q[ex_idx];
    ex_typ = br_type_e'(ex_type);
    ex_hit = ex_ent.vld && (ex_ent.tag == ex_tag);
    ex_tkn = (ex_typ != BR_COND) || ex_taken;
    if (ex_vld) begin
      if (ex_hit) begin
        btb_d[ex_idx].tar = ex_tar;
        btb_d[ex_idx].typ = ex_typ;
        btb_d[ex_idx].cnt = (ex_typ == BR_COND) ? cnt_update(ex_ent.cnt, ex_taken) : CNT_ST;
      end else if (ex_tkn) begin
        btb_d[ex_idx] = '{vld: 1'b1, tag: ex_tag, tar: ex_tar, typ: ex_typ,
                          cnt: (ex_typ == BR_COND) ? CNT_WT : CNT_ST};
      end
    end
  end

  // BTB and prediction registers with synchronous clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{vld: 1'b0, tag: '0, tar: '0, typ: BR_COND, cnt: CNT_WNT};
      end
      pd_vld_q     <= 1'b0;
      pd_pc_q      <= '0;
      pd_taken_q   <= 1'b0;
      pd_lane_q    <= '0;
      pd_ras_ptr_q <= '0;
    end else begin
      btb_q        <= btb_d;
      pd_vld_q     <= pd_vld_d;
      pd_pc_q      <= pd_pc_d;
      pd_taken_q   <= pd_taken_d;
      pd_lane_q    <= pd_lane_d;
      pd_ras_ptr_q <= pd_ras_ptr_d;
    end
  end

  assign pd_vld     = pd_vld_q;
  assign pd_pc      = pd_pc_q;
  assign pd_taken   = pd_taken_q;
  assign pd_lane    = pd_lane_q;
  assign pd_ras_ptr = pd_ras_ptr_q;

endmodule
